// File: rtl/ex_stage_pkg.sv
// Shared widths, operation codes and divider state encoding for the execute stage.
package ex_stage_pkg;

   localparam int ALUOP_W   = 8;
   localparam int ALUSEL_W  = 3;
   localparam int REGADDR_W = 5;

   // Result classes (ex_alusel)
   localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'd0;
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'd1;
   localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'd2;
   localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'd3;
   localparam logic [ALUSEL_W-1:0] EXE_RES_JUMP  = 3'd4;
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD  = 3'd5;
   localparam logic [ALUSEL_W-1:0] EXE_RES_STORE = 3'd6;
   localparam logic [ALUSEL_W-1:0] EXE_RES_DIV   = 3'd7;

   // Operations (ex_aluop)
   localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'h00;
   localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'h01;
   localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'h02;
   localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'h03;
   localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'h04;
   localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'h05;
   localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'h06;
   localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 8'h07;
   localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = 8'h08;
   localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'h09;
   localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'h0a;
   localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'h10;
   localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'h11;
   localparam logic [ALUOP_W-1:0] EXE_REM_OP  = 8'h12;
   localparam logic [ALUOP_W-1:0] EXE_REMU_OP = 8'h13;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
             (op == EXE_REM_OP) || (op == EXE_REMU_OP);
   endfunction

   function automatic logic is_signed_div(input logic [ALUOP_W-1:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_REM_OP);
   endfunction

   function automatic logic is_rem_op(input logic [ALUOP_W-1:0] op);
      return (op == EXE_REM_OP) || (op == EXE_REMU_OP);
   endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider: IDLE/BUSY/DONE FSM over operand magnitudes,
// with sign correction of quotient and remainder applied on the DONE outputs.
module div_iter
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            signed_op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            abort,
   input  logic            hold,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;

   // quo_q starts as the dividend magnitude and fills with quotient bits from the LSB
   assign trial = {rem_q, quo_q[XLEN-1]};
   assign diff  = trial - {1'b0, dvs_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               state_d   = DIV_BUSY;
               cnt_d     = '0;
               rem_d     = '0;
               quo_d     = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
               dvs_d     = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
               neg_quo_d = signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
               neg_rem_d = signed_op && dividend[XLEN-1];
            end
         end
         DIV_BUSY: begin
            if (diff[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
               rem_d = diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (!hold) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (abort) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign busy      = (state_q == DIV_BUSY);
   assign done      = (state_q == DIV_DONE);
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, load/store address adder, divide special-case
// resolution and the stall/write-enable logic around the iterative divider.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_hold,
   input  logic                 flush,
   input  logic [ALUOP_W-1:0]   ex_aluop,
   input  logic [ALUSEL_W-1:0]  ex_alusel,
   input  logic [XLEN-1:0]      ex_opv1,
   input  logic [XLEN-1:0]      ex_opv2,
   input  logic [REGADDR_W-1:0] ex_reg_waddr,
   input  logic                 ex_we,
   input  logic [XLEN-1:0]      ex_link_addr,
   input  logic [XLEN-1:0]      ex_mem_offset,
   output logic [XLEN-1:0]      wb_wdata,
   output logic [REGADDR_W-1:0] wb_waddr,
   output logic                 wb_we,
   output logic [ALUOP_W-1:0]   mem_aluop,
   output logic [XLEN-1:0]      mem_addr,
   output logic [XLEN-1:0]      mem_sdata,
   output logic                 stall_req,
   output logic                 div_busy
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0]  shamt;
   logic            is_div, div_signed, div_rem;
   logic            div_by_zero, div_ovf, div_special, div_start;
   logic            dv_busy, dv_done;
   logic [XLEN-1:0] dv_quo, dv_rem;
   logic [XLEN-1:0] spec_quo, spec_rem, div_res, alu_res;

   assign shamt       = ex_opv2[SHW-1:0];
   assign is_div      = (ex_alusel == EXE_RES_DIV) && is_div_op(ex_aluop);
   assign div_signed  = is_signed_div(ex_aluop);
   assign div_rem     = is_rem_op(ex_aluop);
   assign div_by_zero = (ex_opv2 == '0);
   assign div_ovf     = div_signed && (ex_opv1 == {1'b1, {(XLEN-1){1'b0}}}) && (&ex_opv2);
   assign div_special = div_by_zero || div_ovf;

   // Overflow quotient equals the dividend (most negative value); remainder is 0
   assign spec_quo = div_by_zero ? '1 : ex_opv1;
   assign spec_rem = div_by_zero ? ex_opv1 : '0;

   assign div_start = is_div && !div_special && !flush;

   div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .signed_op (div_signed),
      .dividend  (ex_opv1),
      .divisor   (ex_opv2),
      .abort     (flush),
      .hold      (stall_hold),
      .busy      (dv_busy),
      .done      (dv_done),
      .quotient  (dv_quo),
      .remainder (dv_rem)
   );

   assign div_busy  = dv_busy || dv_done;
   assign stall_req = !rst && !flush && (dv_busy || (!div_busy && div_start));

   always_comb begin
      div_res = '0;
      if (dv_done)
         div_res = div_rem ? dv_rem : dv_quo;
      else if (!div_busy && is_div && div_special)
         div_res = div_rem ? spec_rem : spec_quo;
   end

   always_comb begin
      alu_res = '0;
      case (ex_alusel)
         EXE_RES_LOGIC: begin
            case (ex_aluop)
               EXE_AND_OP: alu_res = ex_opv1 & ex_opv2;
               EXE_OR_OP:  alu_res = ex_opv1 | ex_opv2;
               EXE_XOR_OP: alu_res = ex_opv1 ^ ex_opv2;
               default:    alu_res = '0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (ex_aluop)
               EXE_SLL_OP: alu_res = ex_opv1 << shamt;
               EXE_SRL_OP: alu_res = ex_opv1 >> shamt;
               EXE_SRA_OP: alu_res = $unsigned($signed(ex_opv1) >>> shamt);
               default:    alu_res = '0;
            endcase
         end
         EXE_RES_ARITH: begin
            case (ex_aluop)
               EXE_ADD_OP:  alu_res = ex_opv1 + ex_opv2;
               EXE_SUB_OP:  alu_res = ex_opv1 - ex_opv2;
               EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex_opv1) < $signed(ex_opv2))};
               EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, (ex_opv1 < ex_opv2)};
               default:     alu_res = '0;
            endcase
         end
         EXE_RES_JUMP: alu_res = ex_link_addr;
         EXE_RES_DIV:  alu_res = div_res;
         default:      alu_res = '0;
      endcase
   end

   assign wb_wdata  = alu_res;
   assign wb_waddr  = ex_reg_waddr;
   assign wb_we     = ex_we && !stall_req && !flush;
   assign mem_aluop = ex_aluop;
   assign mem_addr  = ex_opv1 + ex_mem_offset;
   assign mem_sdata = ex_opv2;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline. It sits between the ID/EX register and the EX/MEM register. Single-cycle ALU operations resolve combinationally. Signed and unsigned divide and remainder run on an iterative radix-2 divider, and a stall request holds the upstream pipeline until the result is ready.

## Interface
- Parameter `XLEN`, default 32: datapath width; iteration count equals `XLEN`.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stall_hold`  in  1  EX/MEM not advancing this cycle (downstream stall)
- `flush`  in  1  kill the in-flight EX operation (branch redirect)
- `ex_aluop`  in  `AluOpBus`  operation from ID/EX
- `ex_alusel`  in  `AluSelBus`  result class from ID/EX
- `ex_opv1`, `ex_opv2`  in  `RegBus`  operands
- `ex_reg_waddr`  in  `RegAddrBus`  destination register
- `ex_we`  in  1  register write enable
- `ex_link_addr`  in  `InstAddrBus`  return address for jumps
- `ex_mem_offset`  in  `RegBus`  load/store offset
- `wb_wdata`  out  `RegBus`  result to EX/MEM
- `wb_waddr`  out  `RegAddrBus`  passthrough of `ex_reg_waddr`
- `wb_we`  out  1  write enable to EX/MEM
- `mem_aluop`  out  `AluOpBus`  passthrough for the MEM stage
- `mem_addr`  out  `RegBus`  `ex_opv1 + ex_mem_offset`, modulo 2^XLEN
- `mem_sdata`  out  `RegBus`  store data, `ex_opv2`
- `stall_req`  out  1  request to hold PC, IF/ID and ID/EX
- `div_busy`  out  1  divider FSM not in IDLE

## Operation
- **Result selection by `ex_alusel`:**
  - LOGIC: AND/OR/XOR.
  - SHIFT: SLL/SRL/SRA, amount `opv2[4:0]`.
  - ARITH: ADD/SUB/SLT/SLTU.
  - JUMP: `ex_link_addr`.
  - LOAD/STORE: `wb_wdata` = 0.
  - DIV class: divider result.
  - NOP: 0.
- **Divide ops:** `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_REM_OP`, `EXE_REMU_OP`.
- **Special cases**, resolved in IDLE with no stall:
  - Divisor 0: quotient all-ones; remainder = dividend.
  - Signed `-2^(XLEN-1) / -1`: quotient `-2^(XLEN-1)`; remainder 0.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE → BUSY: a divide op is present, it is not a special case, and `flush` = 0.
    - Latch operand magnitudes and sign flags.
    - Set count = 0.
    - `stall_req` = 1 combinationally in this same cycle.
  - BUSY: one restoring-division step per cycle, count + 1.
    - After step `XLEN` (count = XLEN-1), go to DONE.
    - `stall_req` = 1 throughout.
  - DONE: sign correction is applied.
    - Quotient negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
    - `stall_req` = 0 and the result drives `wb_wdata`.
  - DONE → IDLE when `stall_hold` = 0.
    - DONE is held while `stall_hold` = 1, so the ID/EX op still present does not restart the divide.
  - `flush` or `rst` in any state: go to IDLE and drop `stall_req` in the same cycle.
- **Write-enable gating:** `wb_we` = `ex_we & ~stall_req & ~flush`.
- **Latched operands:** the divider uses the operands latched at IDLE → BUSY. Changes on `ex_opv*` while BUSY are ignored.

## Timing
- Single-cycle ops: zero added latency; outputs are combinational from the ID/EX inputs.
- Non-special divide arriving at cycle T:
  - `stall_req` is high during T .. T+XLEN (33 cycles at XLEN = 32).
  - Result is valid at T+XLEN+1, with `stall_req` low in that cycle.
  - The EX/MEM register captures it at the end of T+XLEN+1.
- Special-case divide: result is valid in T; no stall.
- Reset values (after a cycle with `rst` = 1):
  - FSM in IDLE, count 0.
  - `stall_req` = 0, `div_busy` = 0.
  - All other outputs are 0, because ID/EX delivers NOP and zeros under `rst`.
- Back-to-back divides: the second one enters IDLE → BUSY in the cycle after DONE exits.

## Structure
- `defines.v` holds:
  - the four divide aluop codes and the `EXE_RES_DIV` alusel code;
  - the FSM state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`;
  - the existing bus width macros.
- Sub-module `div_iter`: the FSM, the shift/subtract datapath and sign correction.
  - Inputs: `start`, `signed_op`, `dividend`, `divisor`, `abort`, `hold`.
  - Outputs: `busy`, `done`, `quotient`, `remainder`.
- `ex_stage` contains the ALU mux, address adder, special-case detection and `stall_req`/`wb_we` logic.

## Test plan
- **ALU baseline:** ADD 0x7FFFFFFF + 1 → `wb_wdata` 0x80000000, `stall_req` 0. SRA 0x80000000 by 4 → 0xF8000000.
- **Signed divide:** DIV -7 / 2 → `stall_req` high 33 cycles, then quotient 0xFFFFFFFD. REM -7 / 2 → 0xFFFFFFFF. `wb_we` low throughout the stall.
- **Unsigned divide, special cases:**
  - DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF.
  - DIV x / 0 → 0xFFFFFFFF with no stall.
  - DIV 0x80000000 / -1 → 0x80000000 with no stall.
- **Aborts:** `flush` at BUSY cycle 10 → IDLE next cycle, `stall_req` 0, `wb_we` 0. `rst` at BUSY cycle 20 behaves the same, with all outputs zeroed.
- **Downstream hold:** `stall_hold` = 1 for 3 cycles at DONE → DONE held, `wb_wdata` stable, no restart. Release → IDLE, and the next divide starts normally.
- **Back-to-back and operand changes:** DIVU 100 / 7 then REMU 100 / 7 → results 14 and 2, each after its own 33-cycle stall. Changing `ex_opv1` mid-BUSY does not alter the result.
